// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux -- four-digit multiplexed 7-segment scanner.
//
// Each digit is shown for CLK_DIV cycles (SHOW). It is then followed by
// BLANK_CYCLES of dead time (BLANK) with every digit off. After that the
// next digit is selected. A value captured with i_load waits in a pending
// register. It moves into the displayed (active) register only at the
// digit 3 -> digit 0 wrap, so a frame never changes mid-scan.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to switch off leading
// zero digits (digits 3..1). Digit 0 is always lit.
//
// Parameters:
//   CLK_DIV       SHOW cycles per digit (2..65535)
//   BLANK_CYCLES  BLANK cycles between digits (0..255, 0 = no BLANK state)
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_value      four nibbles, nibble k drives digit k (digit 0 rightmost)
//   i_load       single-cycle strobe capturing i_value into pending
//   o_bcd        nibble of the current digit (held during BLANK)
//   o_digit_sel  one-hot active-low digit select
//   o_blank      high when no digit is driven
//   o_frame      one-cycle pulse at the 3 -> 0 wrap
//   o_pending    high while a loaded value awaits transfer
module seg7_scan_mux #(
  parameter int unsigned CLK_DIV      = 25000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_value,
  input  logic        i_load,
  output logic [3:0]  o_bcd,
  output logic [3:0]  o_digit_sel,
  output logic        o_blank,
  output logic        o_frame,
  output logic        o_pending
);

  localparam logic [15:0] SHOW_LAST  = 16'(CLK_DIV - 1);
  localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam logic [15:0] BLANK_LAST = HAS_BLANK ? 16'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {
    ST_SHOW,
    ST_BLANK
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] active;
  logic [15:0] pending;

  logic [3:0]  cur_nib;
  logic        suppress;
  logic        digit_end;
  logic        wrap;

  always_comb begin
    cur_nib = 4'(active >> {idx, 2'b00});
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when nibbles k..3 are all zero.
  always_comb begin
    suppress = 1'b0;
    case (idx)
      2'd1:    suppress = (active[15:4]  == '0);
      2'd2:    suppress = (active[15:8]  == '0);
      2'd3:    suppress = (active[15:12] == '0);
      default: suppress = 1'b0;
    endcase
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  // Last cycle of a digit period: end of BLANK, or end of SHOW when BLANK is skipped.
  always_comb begin
    digit_end = 1'b0;
    if (state == ST_SHOW) begin
      digit_end = (cnt == SHOW_LAST) && !HAS_BLANK;
    end else begin
      digit_end = (cnt == BLANK_LAST);
    end
    wrap = digit_end && (idx == 2'd3);
  end

  // The output registers show the state of the cycle that has just ended.
  // So the outputs trail the internal state by one cycle. This lets the
  // first edge after reset show digit 0 for a full CLK_DIV cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_SHOW;
      cnt         <= '0;
      idx         <= '0;
      active      <= '0;
      pending     <= '0;
      o_pending   <= 1'b0;
      o_frame     <= 1'b0;
      o_bcd       <= '0;
      o_digit_sel <= '1;
      o_blank     <= 1'b1;
    end else begin
      if (state == ST_SHOW) begin
        o_bcd <= cur_nib;
        if (suppress) begin
          o_digit_sel <= '1;
          o_blank     <= 1'b1;
        end else begin
          o_digit_sel <= ~(4'b0001 << idx);
          o_blank     <= 1'b0;
        end
      end else begin
        o_digit_sel <= '1;
        o_blank     <= 1'b1;
      end

      o_frame <= wrap;

      case (state)
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (HAS_BLANK) begin
              state <= ST_BLANK;
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= ST_SHOW;
            idx   <= idx + 2'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_SHOW;
          cnt   <= '0;
        end
      endcase

      // A load on the wrap edge stays pending while the older value goes live.
      if (wrap && o_pending) begin
        active <= pending;
      end
      if (i_load) begin
        pending   <= i_value;
        o_pending <= 1'b1;
      end else if (wrap) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux -- self-checking bench for seg7_scan_mux.
// Drives two instances from the same inputs. Instance 0 uses CLK_DIV=4,
// BLANK_CYCLES=2. Instance 1 uses CLK_DIV=4, BLANK_CYCLES=0. The reference
// model works out each expected output from the number of edges since
// reset. Using plain period arithmetic, it finds the digit, the phase and
// the frame boundary. It then replays the pending/active load rules.
module tb_seg7_scan_mux;

  localparam int unsigned CD [2] = '{4, 4};
  localparam int unsigned BC [2] = '{2, 0};

  logic        clk;
  logic        rst_n;
  logic [15:0] i_value;
  logic        i_load;

  logic [1:0][3:0] bcd_w;
  logic [1:0][3:0] sel_w;
  logic [1:0]      blank_w;
  logic [1:0]      frame_w;
  logic [1:0]      pend_w;

  seg7_scan_mux #(.CLK_DIV(4), .BLANK_CYCLES(2)) u_dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .o_bcd      (bcd_w[0]),
    .o_digit_sel(sel_w[0]),
    .o_blank    (blank_w[0]),
    .o_frame    (frame_w[0]),
    .o_pending  (pend_w[0])
  );

  seg7_scan_mux #(.CLK_DIV(4), .BLANK_CYCLES(0)) u_dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .o_bcd      (bcd_w[1]),
    .o_digit_sel(sel_w[1]),
    .o_blank    (blank_w[1]),
    .o_frame    (frame_w[1]),
    .o_pending  (pend_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned k;

  logic [15:0] m_act  [2];
  logic [15:0] m_pend [2];
  logic        m_pflag[2];
  logic [3:0]  m_bcd  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]   = '0;
      m_pend[i]  = '0;
      m_pflag[i] = 1'b0;
      m_bcd[i]   = '0;
    end
    k = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_i%0d_sel", tag, i),   32'(sel_w[i]),   32'hF);
      check($sformatf("%s_i%0d_blank", tag, i), 32'(blank_w[i]), 32'h1);
      check($sformatf("%s_i%0d_bcd", tag, i),   32'(bcd_w[i]),   32'h0);
      check($sformatf("%s_i%0d_frame", tag, i), 32'(frame_w[i]), 32'h0);
      check($sformatf("%s_i%0d_pend", tag, i),  32'(pend_w[i]),  32'h0);
    end
  endtask

  // Edge k shows the display slot n = k-1 counted from reset release.
  task automatic model_edge(input int i, input logic ld, input logic [15:0] v);
    int unsigned p, n, dig, ph;
    logic        show, lz, wrap;
    logic [3:0]  esel;
    p    = CD[i] + BC[i];
    n    = k - 1;
    dig  = (n / p) % 4;
    ph   = n % p;
    show = (ph < CD[i]);
    lz   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz   = (dig != 0) && ((m_act[i] >> (4 * dig)) == 16'h0);
`endif
    if (show) m_bcd[i] = m_act[i][4*dig +: 4];
    esel = (show && !lz) ? ~(4'b0001 << dig) : 4'hF;
    wrap = (k % (4 * p)) == 0;
    check($sformatf("i%0d_sel_k%0d", i, k),   32'(sel_w[i]),   32'(esel));
    check($sformatf("i%0d_blank_k%0d", i, k), 32'(blank_w[i]), 32'(!(show && !lz)));
    check($sformatf("i%0d_bcd_k%0d", i, k),   32'(bcd_w[i]),   32'(m_bcd[i]));
    check($sformatf("i%0d_frame_k%0d", i, k), 32'(frame_w[i]), 32'(wrap));
    if (wrap && m_pflag[i]) m_act[i] = m_pend[i];
    if (wrap) m_pflag[i] = 1'b0;
    if (ld) begin
      m_pend[i]  = v;
      m_pflag[i] = 1'b1;
    end
    check($sformatf("i%0d_pend_k%0d", i, k), 32'(pend_w[i]), 32'(m_pflag[i]));
  endtask

  task automatic step(input logic ld, input logic [15:0] v);
    i_load  = ld;
    i_value = v;
    @(posedge clk);
    #1;
    k++;
    for (int i = 0; i < 2; i++) model_edge(i, ld, v);
    i_load = 1'b0;
  endtask

  int unsigned sk [6] = '{49, 100, 110, 150, 168, 190};
  logic [15:0] sv [6] = '{16'h1234, 16'h1111, 16'h5678, 16'h1234, 16'hABCD, 16'h9999};

  initial begin
    logic        ld;
    logic [15:0] v;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_load  = 1'b0;
    i_value = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Directed schedule: mid-frame load, two loads in one frame,
    // a load on instance 0's wrap edge (168) while 1234 is pending, then 9999.
    while (k < 240) begin
      ld = 1'b0;
      v  = '0;
      for (int j = 0; j < 6; j++) begin
        if (sk[j] == k + 1) begin
          ld = 1'b1;
          v  = sv[j];
        end
      end
      step(ld, v);
    end
    check("act9999_i0", 32'(m_act[0]), 32'h9999);

    // Reset asserted while instance 0 is in BLANK.
    while ((k % 6) != 4) step(1'b0, '0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("hold");
    rst_n = 1'b1;

    // Randomized loads, zero-heavy values, extra loads aimed at wrap edges.
    for (int c = 0; c < 1500; c++) begin
      ld = ($urandom_range(0, 7) == 0);
      if (((k + 1) % 24) == 0 || ((k + 1) % 16) == 0) ld = ld | ($urandom_range(0, 1) == 1);
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        2: v = '0;
        default: ;
      endcase
      step(ld, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
